// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter slice.
package uart_pkg;

    localparam int unsigned UART_DATA_W      = 8;
    localparam int unsigned CNT_W            = 8;
    localparam int unsigned FRAME_CYCLES_DFLT = 11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        BUSY = 2'd2,
        GAP  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester-side and serializer-side signals of the UART transmit arbiter.
interface uart_tx_arbiter_if
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4
);
    localparam int unsigned IW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]             req_valid;
    logic [UART_DATA_W*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           tx_valid;
    logic [UART_DATA_W-1:0]         tx_data;
    logic [IW-1:0]                  grant_id;
    logic                           busy;

    modport master (
        output req_valid, req_data,
        input  req_ready, tx_valid, tx_data, grant_id, busy
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, tx_valid, tx_data, grant_id, busy
    );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from ptr_i+1 upward, wrapping.
module rr_arbiter #(
    parameter  int unsigned N  = 4,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    logic [IW-1:0] cand;
    logic          found;

    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        cand  = '0;
        found = 1'b0;
        for (int unsigned k = 1; k <= N; k++) begin
            cand = IW'((32'(ptr_i) + k) % N);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                gnt_o[cand] = 1'b1;
                idx_o       = cand;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one strobe-driven UART serializer among NUM_REQ producers.
// Optional macro UART_ARB_PRIO_EN: requester 0 pre-empts the round-robin order.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned FRAME_CYCLES = FRAME_CYCLES_DFLT,
    parameter int unsigned GAP_CYCLES   = 0
) (
    input logic              clk,
    input logic              rst,
    uart_tx_arbiter_if.slave bus
);

    localparam int unsigned IW = $clog2(NUM_REQ);
    localparam int unsigned DW = UART_DATA_W;

    arb_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IW-1:0]    last_q;
    logic             tx_valid_q;
    logic [DW-1:0]    tx_data_q;
    logic [IW-1:0]    grant_id_q;
    logic             busy_q;

    logic [NUM_REQ-1:0] arb_req;
    logic [NUM_REQ-1:0] rr_gnt;
    logic [IW-1:0]      rr_idx;
    logic               rr_any;
    logic               prio_hit;
    logic [NUM_REQ-1:0] win_gnt;
    logic [IW-1:0]      win_idx;
    logic               win_any;
    logic [DW-1:0]      win_data;
    logic               accept;

`ifdef UART_ARB_PRIO_EN
    // Requester 0 bypasses the pointer; the others rotate among themselves.
    assign arb_req  = bus.req_valid & ~NUM_REQ'(1);
    assign prio_hit = bus.req_valid[0];
`else
    assign arb_req  = bus.req_valid;
    assign prio_hit = 1'b0;
`endif

    rr_arbiter #(.N(NUM_REQ)) u_rr (
        .req_i (arb_req),
        .ptr_i (last_q),
        .gnt_o (rr_gnt),
        .idx_o (rr_idx),
        .any_o (rr_any)
    );

    assign win_gnt  = prio_hit ? NUM_REQ'(1) : rr_gnt;
    assign win_idx  = prio_hit ? '0 : rr_idx;
    assign win_any  = prio_hit | rr_any;
    assign win_data = bus.req_data[32'(win_idx)*DW +: DW];
    assign accept   = rst && (state_q == IDLE) && win_any;

    assign bus.req_ready = accept ? win_gnt : '0;
    assign bus.tx_valid  = tx_valid_q;
    assign bus.tx_data   = tx_data_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.busy      = busy_q;

    // Frame timing FSM; the strobe is registered so it lands one cycle after acceptance.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            last_q     <= IW'(NUM_REQ - 1);
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            grant_id_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            tx_valid_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        tx_data_q  <= win_data;
                        grant_id_q <= win_idx;
                        tx_valid_q <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= SEND;
                        if (!prio_hit) begin
                            last_q <= win_idx;
                        end
                    end
                end
                SEND: begin
                    cnt_q   <= CNT_W'(FRAME_CYCLES - 2);
                    state_q <= BUSY;
                end
                BUSY: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        if (GAP_CYCLES != 0) begin
                            cnt_q   <= CNT_W'(GAP_CYCLES);
                            state_q <= GAP;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                GAP: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - CNT_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a cycle model predicts grants, strobes and busy.
module tb_uart_tx_arbiter;

    localparam int unsigned N  = 4;
    localparam int unsigned F  = 11;
    localparam int unsigned G  = 0;
    localparam int unsigned GG = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst_g;
    logic gap_done = 1'b0;

    uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();
    uart_tx_arbiter_if #(.NUM_REQ(N)) bus_g ();

    uart_tx_arbiter #(.NUM_REQ(N), .FRAME_CYCLES(F), .GAP_CYCLES(G)) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    uart_tx_arbiter #(.NUM_REQ(N), .FRAME_CYCLES(F), .GAP_CYCLES(GG)) dut_g (
        .clk (clk),
        .rst (rst_g),
        .bus (bus_g)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    typedef struct {
        int         id;
        logic [7:0] data;
        int         cyc;
    } exp_t;

    exp_t       sb [$];
    logic [7:0] src [N][$];

    int         cyc;
    int         m_free;
    int         m_ptr;
    int         m_gid;
    logic [7:0] m_txd;

    // Reference arbitration: first valid requester after the pointer, wrapping.
    function automatic int model_pick(input logic [N-1:0] v);
        int c;
`ifdef UART_ARB_PRIO_EN
        if (v[0]) return 0;
`endif
        for (int k = 1; k <= int'(N); k++) begin
            c = (m_ptr + k) % int'(N);
`ifdef UART_ARB_PRIO_EN
            if (c != 0 && v[c]) return c;
`else
            if (v[c]) return c;
`endif
        end
        return -1;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < int'(N); i++) begin
            bus.req_valid[i]       = (src[i].size() > 0);
            bus.req_data[i*8 +: 8] = (src[i].size() > 0) ? src[i][0] : 8'h00;
        end
    endtask

    task automatic step();
        int         w;
        logic [N-1:0] exp_rdy;
        logic       exp_tv;
        exp_t       e;
        drive_inputs();
        #1;
        exp_rdy = '0;
        if (!rst_n) begin
            m_free = cyc + 1;
            m_ptr  = int'(N) - 1;
            m_txd  = 8'h00;
            m_gid  = 0;
            sb.delete();
        end else if (cyc >= m_free) begin
            w = model_pick(bus.req_valid);
            if (w >= 0) begin
                exp_rdy[w] = 1'b1;
                sb.push_back('{w, src[w][0], cyc + 1});
                m_txd  = src[w][0];
                m_gid  = w;
                m_free = cyc + int'(F + G);
`ifdef UART_ARB_PRIO_EN
                if (w != 0) m_ptr = w;
`else
                m_ptr = w;
`endif
                void'(src[w].pop_front());
            end
        end
        check_eq("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        @(posedge clk);
        #1;
        cyc++;
        exp_tv = (sb.size() > 0) && (sb[0].cyc == cyc);
        check_eq("tx_valid", 32'(bus.tx_valid), 32'(exp_tv));
        if (exp_tv) begin
            e = sb.pop_front();
            check_eq("strobe_id", 32'(bus.grant_id), 32'(e.id));
            check_eq("strobe_data", 32'(bus.tx_data), 32'(e.data));
        end
        check_eq("tx_data_hold", 32'(bus.tx_data), 32'(m_txd));
        check_eq("grant_id_hold", 32'(bus.grant_id), 32'(m_gid));
        check_eq("busy", 32'(bus.busy), 32'(cyc < m_free));
        @(negedge clk);
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Main DUT: single byte, full contention, late arrival, withdrawal, mid-frame reset, priority.
    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        cyc    = 0;
        m_free = 0;
        m_ptr  = int'(N) - 1;
        m_gid  = 0;
        m_txd  = 8'h00;
        @(negedge clk);
        run(3);
        rst_n = 1'b1;

        src[0].push_back(8'hA5);
        run(15);

        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < int'(N); i++) begin
                src[i].push_back(8'(8'h10 + 8'(i) * 8'h11));
            end
        end
        run(95);

        src[0].push_back(8'h66);
        run(4);
        src[2].push_back(8'h77);
        run(20);

        src[0].push_back(8'h01);
        run(2);
        src[1].push_back(8'hBB);
        run(3);
        src[1].delete();
        src[3].push_back(8'hCC);
        run(15);

        src[1].push_back(8'h5A);
        run(5);
        src[3].push_back(8'h3C);
        src[0].push_back(8'hC3);
        rst_n = 1'b0;
        run(1);
        rst_n = 1'b1;
        run(30);

        for (int k = 0; k < 4; k++) begin
            src[0].push_back(8'(8'hE0 + 8'(k)));
            src[1].push_back(8'(8'hF0 + 8'(k)));
        end
        run(30);
        src[0].delete();
        run(60);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        check_eq("gap_done", 32'(gap_done), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    // Gap DUT: one continuous requester must see strobes FRAME+GAP cycles apart.
    initial begin
        int t;
        int last_t;
        int nstrobe;
        rst_g           = 1'b0;
        bus_g.req_valid = '0;
        bus_g.req_data  = '0;
        repeat (3) @(negedge clk);
        rst_g           = 1'b1;
        bus_g.req_valid = 4'b0100;
        bus_g.req_data  = 32'h005C_0000;
        t       = 0;
        last_t  = -1;
        nstrobe = 0;
        repeat (70) begin
            @(posedge clk);
            #1;
            t++;
            if (bus_g.tx_valid) begin
                check_eq("gap_data", 32'(bus_g.tx_data), 32'h5C);
                check_eq("gap_id", 32'(bus_g.grant_id), 32'd2);
                if (last_t >= 0) begin
                    check_eq("gap_spacing", 32'(t - last_t), 32'(F + GG));
                end
                last_t = t;
                nstrobe++;
            end
        end
        check_eq("gap_strobes", 32'(nstrobe >= 4), 32'd1);
        gap_done = 1'b1;
    end

endmodule
